bitrev_job_ctrl: RTL
====================

Name: bitrev_job_ctrl

Overview:
- Sequences one bit-reversal job end to end:
  - pops num_words input words from the host input FIFO;
  - streams them as AXI-Stream (tdata/tvalid/tlast) into the bit-reversal result buffer;
  - waits for that buffer's done flag;
  - issues read pulses to drain the results into the host output FIFO;
  - raises a completion interrupt.
- Sits between the host-side FIFOs and the bit-reversal core. It is the only master of the core's stream input and read strobe.

Parameters:
- DATA_WIDTH, 32, word width of all data paths.
- MAX_WORDS, 4, largest legal job length. Equals the core's internal buffer depth.
- CNT_W, 3, width of num_words and the internal counters. Must satisfy 2^CNT_W > MAX_WORDS.
- TIMEOUT, 1024, maximum cycles spent in WAIT_DONE before the job is aborted.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job request. Ignored while busy=1.
- num_words  in  CNT_W  job length, sampled when start is accepted.
- busy  out  1  high from the cycle after an accepted start until the job ends.
- irq  out  1  one-cycle pulse at job end (success or error).
- err  out  1  sticky error flag. Cleared on the next accepted start.
- in_empty  in  1  input FIFO empty (first-word-fall-through).
- in_data  in  DATA_WIDTH  input FIFO head word.
- in_rd  out  1  input FIFO pop.
- m_tdata  out  DATA_WIDTH  stream data to the core.
- m_tvalid  out  1  stream valid.
- m_tlast  out  1  marks the final word of the job.
- m_tready  in  1  core ready_for_results.
- res_done  in  1  core result buffer full and readable.
- res_read  out  1  one-cycle read strobe to the core.
- res_data  in  DATA_WIDTH  core dout. Valid from the cycle after res_read until the next res_read.
- out_full  in  1  output FIFO full.
- out_wr  out  1  output FIFO push.
- out_data  out  DATA_WIDTH  output FIFO write data.

Behaviour:
- Reset: state=IDLE; counters=0; pending=0. busy, irq, err, in_rd, m_tvalid, m_tlast, res_read and out_wr are all 0. Reset mid-job aborts immediately, with no irq.
- States: IDLE, STREAM, WAIT_DONE, DRAIN, COMPLETE, ERROR.
- IDLE:
  - start accepted: latch len=num_words, clear err and all counters.
  - len==0 or len>MAX_WORDS: go to ERROR.
  - Otherwise: go to STREAM, busy=1.
- STREAM:
  - m_tvalid = !in_empty (combinational). m_tdata = in_data.
  - m_tlast = m_tvalid and (sent_cnt == len-1).
  - in_rd = m_tvalid & m_tready, which is also the transfer condition.
  - On each transfer, sent_cnt increments.
  - A transfer with m_tlast set moves to WAIT_DONE.
  - No timeout applies in STREAM.
- WAIT_DONE:
  - A wait counter starts at 0 on entry.
  - res_done=1 goes to DRAIN.
  - If the counter reaches TIMEOUT-1 with res_done still low, go to ERROR.
  - res_done observed on the same cycle as the limit wins, and the FSM goes to DRAIN.
- DRAIN (exactly one outstanding read):
  - res_read = !pending & (rd_cnt < len). On res_read: pending<=1 and rd_cnt++.
  - While pending: out_data = res_data, out_wr = !out_full. When out_wr fires, pending<=0.
  - Throughput is one word per 2 cycles when out_full=0. out_full stalls hold pending, and res_data stays stable because no new read is issued.
  - When rd_cnt==len and pending==0, go to COMPLETE.
  - res_read is never issued more than len times per job.
- COMPLETE: irq=1 for one cycle, busy=0 in the same cycle, then go to IDLE.
- ERROR: err=1 (sticky), irq=1 for one cycle, busy=0, then go to IDLE. No further strobes go to the core or the FIFOs.
- A start asserted in the same cycle as COMPLETE or ERROR is ignored. The next start is accepted in IDLE.
- in_rd, res_read and out_wr are never asserted outside STREAM and DRAIN respectively.
- Counter arithmetic is unsigned CNT_W bits. Comparisons are against len. No wrap is reachable given the parameter constraint.

Test Plan:
- Nominal job: num_words=4, input words 0x1,0x2,0x4,0x8, tready=1, res_done rises 3 cycles after tlast, res_data follows the read order 0x80000000,0x40000000,0x20000000,0x10000000 → exactly 4 in_rd, tlast on the 4th beat only, exactly 4 res_read, and out_wr data in that order. irq one cycle, err=0, busy falls together with irq.
- Backpressure: tready toggles 1,0,1,0 and in_empty=1 for 2 cycles mid-stream → no beat lost or duplicated, and in_rd count equals the beat count (4). During an out_full stall of 5 cycles, out_wr=0 and exactly one read is outstanding.
- Illegal length: num_words=0, then num_words=5 → ERROR directly each time, irq pulse, err=1, no in_rd or res_read.
- Timeout: res_done held low → irq and err at wait cycle 1024. res_done rising on exactly cycle 1023 → normal DRAIN with err=0.
- start while busy, and start coinciding with the irq cycle → ignored. len is unchanged and the job completes with the original 4 words.
- rst asserted mid-DRAIN after 2 reads → all outputs 0 asynchronously, no irq. A new job with num_words=2 then completes normally.

Source files
------------

// File: rtl/bitrev_job_ctrl.sv
// rtl/bitrev_job_ctrl.sv - bit-reversal job sequencer: input FIFO -> core stream -> result drain -> output FIFO
module bitrev_job_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 4,
    parameter int CNT_W      = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_words,
    output logic                  busy,
    output logic                  irq,
    output logic                  err,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_rd,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    input  logic                  res_done,
    output logic                  res_read,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic                  out_full,
    output logic                  out_wr,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  MAX_LEN   = CNT_W'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_DONE,
        S_DRAIN,
        S_COMPLETE,
        S_ERROR
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   sent_cnt;
    logic [CNT_W-1:0]   rd_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               pending;
    logic               err_q;
    logic               accept;
    logic               xfer;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        xfer       = 1'b0;
        m_tvalid   = 1'b0;
        m_tlast    = 1'b0;
        in_rd      = 1'b0;
        res_read   = 1'b0;
        out_wr     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (num_words == '0 || num_words > MAX_LEN) begin
                        next_state = S_ERROR;
                    end else begin
                        next_state = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                m_tvalid = !in_empty;
                m_tlast  = m_tvalid && (sent_cnt == len - CNT_W'(1));
                xfer     = m_tvalid && m_tready;
                in_rd    = xfer;
                if (xfer && m_tlast) begin
                    next_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A done seen on the final allowed cycle still counts as success.
                if (res_done) begin
                    next_state = S_DRAIN;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = S_ERROR;
                end
            end
            S_DRAIN: begin
                res_read = !pending && (rd_cnt < len);
                out_wr   = pending && !out_full;
                if (rd_cnt == len && !pending) begin
                    next_state = S_COMPLETE;
                end
            end
            S_COMPLETE: next_state = S_IDLE;
            S_ERROR:    next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            len      <= '0;
            sent_cnt <= '0;
            rd_cnt   <= '0;
            wait_cnt <= '0;
            pending  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                len      <= num_words;
                sent_cnt <= '0;
                rd_cnt   <= '0;
                wait_cnt <= '0;
                pending  <= 1'b0;
                err_q    <= 1'b0;
            end
            if (xfer) begin
                sent_cnt <= sent_cnt + CNT_W'(1);
            end
            if (state == S_WAIT_DONE) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            // Only one read is ever in flight, so res_data stays put across out_full stalls.
            if (res_read) begin
                pending <= 1'b1;
                rd_cnt  <= rd_cnt + CNT_W'(1);
            end else if (out_wr) begin
                pending <= 1'b0;
            end
            if (next_state == S_ERROR) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy     = (state == S_STREAM) || (state == S_WAIT_DONE) || (state == S_DRAIN);
    assign irq      = (state == S_COMPLETE) || (state == S_ERROR);
    assign err      = err_q;
    assign m_tdata  = in_data;
    assign out_data = res_data;

endmodule
